alm_div8: RTL and testbench
===========================

# alm_div8

Pipelined approximate logarithmic divider for 8-bit signed operands, the inverse-direction companion to the approximate log multiplier in the same datapath family. Both operands pass through leading-one detection to a 6-bit log value; the divisor log is subtracted from the dividend log, and the difference is converted back to linear by antilog shifting. The result is an unsigned 8.8 fixed-point magnitude with a one's-complement sign applied. Three registered stages sit behind a valid/ready handshake and sustain one operation per cycle.

## Interface
- No parameters; all widths are fixed.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  block accepts the pair this cycle.
- a_i  input  8  dividend, signed.
- b_i  input  8  divisor, signed.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- q_o  output  17  quotient: bit 16 is the sign, bits 15:0 are the 8.8 magnitude, one's-complemented as a whole when the sign is set.
- dz_o  output  1  divide-by-zero flag, qualified by out_valid_o.

## Operation
Absolute value uses one's complement, as elsewhere in the family:
- a_abs = a_i ^ {8{a_i[7]}}; b_abs the same way.
- sign = a_i[7] ^ b_i[7].

Log encode, per operand:
- k = index of the leading one of abs, 0..7.
- f = bits [6:4] of (abs << (7-k)), giving a 3-bit fraction.
- L = {k, f}, 6 bits, unsigned.

Subtract:
- D = La − Lb, 7-bit two's complement, range −63..+63.
- kq = D >>> 3, arithmetic, range −8..7.
- fq = D[2:0].

Antilog:
- m = {1, fq}, a 4-bit value of 8..15.
- s = kq + 5.
- If s ≥ 0, mag = m << s. Otherwise mag = m >> −s, truncated.
- mag is 16 bits. The maximum is 15<<12 = 0xF000, so it never overflows.

Output:
- q = {17{sign}} ^ {1'b0, mag}.

Special cases, in priority order:
- b_abs == 0 (b_i = 0 or −1): dz = 1, mag = 0xFFFF, sign applied.
- a_abs == 0 (a_i = 0 or −1): dz = 0, q = 0x00000 with no sign applied.

Pipeline:
- S1 registers L values, sign and the zero flags.
- S2 registers D.
- S3 registers q and dz.
- Each stage holds its own valid bit.

Handshake:
- Stage n loads when its valid is clear or stage n+1 loads this cycle. S3 loads when out_valid_o is clear or out_ready_i is high.
- in_ready_o is the load enable of S1. It is combinational from out_ready_i through the stage valids.
- A transfer happens only when valid and ready are both high on the same edge.
- Data registers hold their value while a stage is stalled.
- q_o and dz_o are stable while out_valid_o = 1 and out_ready_i = 0.
- Results leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset values:
  - out_valid_o = 0, q_o = 0, dz_o = 0.
  - All stage valids = 0, so in_ready_o = 1 immediately after reset.
- Latency: a pair accepted at edge t appears on out_valid_o/q_o after edge t+3 when there is no stall.
- Throughput: one per cycle while out_ready_i is held high.
- Full pipeline with out_ready_i = 0: in_ready_o = 0; at most 3 results are buffered.
- Accept and drain in the same cycle with a full pipeline: all stages advance and in_ready_o = 1.
- Reset asserted mid-operation: all in-flight results are discarded asynchronously and no stale valid is produced after release.
- in_valid_i low: S1 valid clears on its next load; bubbles propagate.

## Configuration
- ALM_DIV_ROUND_EN defined: the right-shift path rounds to nearest, mag = (m + (1 << (−s−1))) >> −s. The left-shift path and the special cases are unchanged.
- Not defined: truncation as in Operation.
- Latency and interface are identical in both builds.

## Test plan
- Exact quotient, no stall: a=64, b=8 -> q=0x00800 (8.0), dz=0, out_valid 3 cycles after accept; a=96, b=3 -> q=0x02000 (32.0).
- Negative dividend: a=−64, b=8 -> La=47, Lb=24, D=23 -> q=0x1F87F, dz=0.
- Right-shift path: a=3, b=127 -> D=−43 -> q=0x00006 without the macro, q=0x00007 with ALM_DIV_ROUND_EN.
- Special cases:
  - a=5, b=0 -> q=0x0FFFF, dz=1.
  - a=5, b=−1 -> q=0x10000, dz=1.
  - a=−1, b=7 -> q=0x00000, dz=0.
  - a=0, b=0 -> dz=1.
- Backpressure: stream 6 pairs with out_ready_i=0 for 8 cycles, then 1.
  - Expect in_ready_o low after the 3rd accept.
  - q_o held stable while stalled.
  - All 6 results emerge in order with no loss.
- Reset mid-flight: accept 2 pairs, pulse rst_ni low between edges -> out_valid_o=0 immediately, in_ready_o=1 after release, no result emitted.

Source files
------------

// File: rtl/alm_div8.sv
// Three-stage approximate logarithmic divider: 8-bit signed operands, 8.8 magnitude with one's-complement sign.
// Optional build macro ALM_DIV_ROUND_EN selects round-to-nearest on the antilog right-shift path.
module alm_div8 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [16:0] q_o,
    output logic        dz_o
);

    function automatic logic [5:0] log_enc(input logic [7:0] v);
        logic [2:0] k;
        logic [2:0] f;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) k = 3'(i);
        end
        f = 3'((v << (3'd7 - k)) >> 4);
        return {k, f};
    endfunction

    logic        s1_v_q, s2_v_q, s3_v_q;
    logic        ld1, ld2, ld3;

    logic [7:0]  a_abs, b_abs;
    logic [5:0]  s1_la_q, s1_lb_q, s1_la_d, s1_lb_d;
    logic        s1_sign_q, s1_az_q, s1_bz_q;

    logic [6:0]  s2_d_q, s2_d_d;
    logic        s2_sign_q, s2_az_q, s2_bz_q;

    logic [16:0] s3_q_q, s3_q_d;
    logic        s3_dz_q, s3_dz_d;

    logic [3:0]  mant;
    logic signed [4:0] shamt;
    logic [1:0]  rsh;
    logic [15:0] mag;

    // Ready ripples backwards from the output so a full pipe can accept and drain together.
    assign ld3        = !s3_v_q || out_ready_i;
    assign ld2        = !s2_v_q || ld3;
    assign ld1        = !s1_v_q || ld2;
    assign in_ready_o = ld1;

    assign a_abs   = a_i ^ {8{a_i[7]}};
    assign b_abs   = b_i ^ {8{b_i[7]}};
    assign s1_la_d = log_enc(a_abs);
    assign s1_lb_d = log_enc(b_abs);
    assign s2_d_d  = {1'b0, s1_la_q} - {1'b0, s1_lb_q};

    always_comb begin
        mant   = {1'b1, s2_d_q[2:0]};
        shamt  = $signed({s2_d_q[6], s2_d_q[6:3]}) + 5'sd5;
        rsh    = 2'(-shamt);
        mag    = '0;
        s3_q_d = '0;
        s3_dz_d = 1'b0;
        if (!shamt[4]) begin
            mag = 16'(mant) << shamt[3:0];
        end else begin
`ifdef ALM_DIV_ROUND_EN
            mag = 16'((5'(mant) + (5'd1 << (rsh - 2'd1))) >> rsh);
`else
            mag = 16'(mant >> rsh);
`endif
        end
        if (s2_bz_q) begin
            s3_dz_d = 1'b1;
            s3_q_d  = {17{s2_sign_q}} ^ {1'b0, 16'hFFFF};
        end else if (s2_az_q) begin
            s3_q_d  = '0;
        end else begin
            s3_q_d  = {17{s2_sign_q}} ^ {1'b0, mag};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s1_la_q   <= '0;
            s1_lb_q   <= '0;
            s1_sign_q <= 1'b0;
            s1_az_q   <= 1'b0;
            s1_bz_q   <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_d_q    <= '0;
            s2_sign_q <= 1'b0;
            s2_az_q   <= 1'b0;
            s2_bz_q   <= 1'b0;
            s3_v_q    <= 1'b0;
            s3_q_q    <= '0;
            s3_dz_q   <= 1'b0;
        end else begin
            if (ld1) begin
                s1_v_q    <= in_valid_i;
                s1_la_q   <= s1_la_d;
                s1_lb_q   <= s1_lb_d;
                s1_sign_q <= a_i[7] ^ b_i[7];
                s1_az_q   <= (a_abs == 8'd0);
                s1_bz_q   <= (b_abs == 8'd0);
            end
            if (ld2) begin
                s2_v_q    <= s1_v_q;
                s2_d_q    <= s2_d_d;
                s2_sign_q <= s1_sign_q;
                s2_az_q   <= s1_az_q;
                s2_bz_q   <= s1_bz_q;
            end
            if (ld3) begin
                s3_v_q    <= s2_v_q;
                s3_q_q    <= s3_q_d;
                s3_dz_q   <= s3_dz_d;
            end
        end
    end

    assign out_valid_o = s3_v_q;
    assign q_o         = s3_q_q;
    assign dz_o        = s3_dz_q;

endmodule

// File: tb/tb_alm_div8.sv
// Scoreboard bench for alm_div8: directed quotients, special cases, backpressure, mid-flight reset, random traffic.
module tb_alm_div8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [16:0] q_o;
    logic        dz_o;

    alm_div8 dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .q_o         (q_o),
        .dz_o        (dz_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [17:0] exp_q[$];
    int acc_cyc_q[$];
    int cyc = 0;
    int last_lat = -1;
    logic held_v = 1'b0;
    logic [16:0] held_q;
    logic held_dz;
    logic last_in_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int log_model(input int x);
        int k;
        k = 0;
        while ((1 << (k + 1)) <= x) k++;
        return k * 8 + (((x * 8) >> k) & 7);
    endfunction

    // Returns {dz, q}
    function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b);
        int aa, bb, d, kq, fq, m, s, mag;
        logic sg;
        aa = a[7] ? 255 - int'(a) : int'(a);
        bb = b[7] ? 255 - int'(b) : int'(b);
        sg = a[7] ^ b[7];
        if (bb == 0) begin
            mag = 65535;
            return {1'b1, sg ? 17'(131071 ^ mag) : 17'(mag)};
        end
        if (aa == 0) return 18'd0;
        d  = log_model(aa) - log_model(bb);
        kq = d >>> 3;
        fq = d - kq * 8;
        m  = 8 + fq;
        s  = kq + 5;
        if (s >= 0) mag = m << s;
`ifdef ALM_DIV_ROUND_EN
        else mag = (m + (1 << (-s - 1))) >> (-s);
`else
        else mag = m >> (-s);
`endif
        return {1'b0, sg ? 17'(131071 ^ mag) : 17'(mag)};
    endfunction

    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy, input logic use_exp, input logic [17:0] expv,
                         output logic accepted);
        logic [17:0] e;
        @(negedge clk_i);
        in_valid_i  = v;
        a_i         = a;
        b_i         = b;
        out_ready_i = ordy;
        #1;
        cyc++;
        if (held_v) begin
            check_eq("hold_valid", 32'(out_valid_o), 32'd1);
            check_eq("hold_q", 32'({dz_o, q_o}), 32'({held_dz, held_q}));
        end
        held_v  = out_valid_o && !out_ready_i;
        held_q  = q_o;
        held_dz = dz_o;
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                last_lat = cyc - acc_cyc_q.pop_front();
                check_eq("q", 32'(q_o), 32'(e[16:0]));
                check_eq("dz", 32'(dz_o), 32'(e[17]));
            end
        end
        last_in_ready = in_ready_o;
        accepted = v && in_ready_o;
        if (accepted) begin
            exp_q.push_back(use_exp ? expv : model(a, b));
            acc_cyc_q.push_back(cyc);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic use_exp, input logic [17:0] expv);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, a, b, 1'b1, use_exp, expv, acc);
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
        cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 18'd0, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 18'd0, acc);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] bp_a[6] = '{8'd64, 8'd96, 8'd200, 8'd17, 8'd3, 8'd127};
    logic [7:0] bp_b[6] = '{8'd8, 8'd3, 8'd5, 8'd250, 8'd127, 8'd1};

    initial begin
        logic acc;
        int idx, first_stall, outs;

        #12;
        check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_q", 32'(q_o), 32'd0);
        check_eq("rst_dz", 32'(dz_o), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready_o), 32'd1);
        rst_ni = 1'b1;

        send(8'd64, 8'd8, 1'b1, {1'b0, 17'h00800});
        drain();
        check_eq("latency", 32'(last_lat), 32'd3);
        send(8'd96, 8'd3, 1'b1, {1'b0, 17'h02000});
        send(-8'sd64, 8'd8, 1'b1, {1'b0, 17'h1F87F});
`ifdef ALM_DIV_ROUND_EN
        send(8'd3, 8'd127, 1'b1, {1'b0, 17'h00007});
`else
        send(8'd3, 8'd127, 1'b1, {1'b0, 17'h00006});
`endif
        send(8'd5, 8'd0, 1'b1, {1'b1, 17'h0FFFF});
        send(8'd5, 8'hFF, 1'b1, {1'b1, 17'h10000});
        send(8'hFF, 8'd7, 1'b1, {1'b0, 17'h00000});
        send(8'd0, 8'd0, 1'b1, {1'b1, 17'h0FFFF});
        drain();

        idx = 0;
        first_stall = -1;
        for (int c = 0; c < 100 && (idx < 6 || exp_q.size() != 0); c++) begin
            cycle(idx < 6, bp_a[idx % 6], bp_b[idx % 6], c >= 8, 1'b0, 18'd0, acc);
            if (c < 8 && !last_in_ready && first_stall < 0) first_stall = idx;
            if (acc) idx++;
        end
        check_eq("bp_stall_after_3", 32'(first_stall), 32'd3);
        check_eq("bp_all_sent", 32'(idx), 32'd6);
        drain();

        cycle(1'b1, 8'd64, 8'd8, 1'b1, 1'b0, 18'd0, acc);
        cycle(1'b1, 8'd96, 8'd3, 1'b1, 1'b0, 18'd0, acc);
        @(posedge clk_i);
        #2;
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid_o), 32'd0);
        exp_q.delete();
        acc_cyc_q.delete();
        held_v = 1'b0;
        #2;
        rst_ni = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready_o), 32'd1);
        outs = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 18'd0, acc);
            if (out_valid_o) outs++;
        end
        check_eq("midrst_no_output", 32'(outs), 32'd0);

        for (int i = 0; i < 300 && (i < 200 || exp_q.size() != 0); i++) begin
            cycle(i < 200 && $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 2) != 0 || i >= 200, 1'b0, 18'd0, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
